// File: rtl/axi_i2c_regif.sv
// axi_i2c_regif
//   AXI4-Lite register front-end of the AXI-to-I2C bridge. Software loads a
//   24-bit command into ADDR_DATA and writes START. The block then presents
//   the command with a valid level, a quiet gap and a trigger level, each held
//   for HOLD_CYCLES so a slow I2C-rate sampler sees it. It then waits for the
//   I2C stage to report an ack or a read byte, or gives up after
//   TIMEOUT_CYCLES. Completion is reflected in STATUS, RDATA and irq.
//
//   Ports
//     clk, resetn            system clock, asynchronous active-low reset
//     s_aw*/s_w*/s_b*        AXI4-Lite write address/data/response channels
//     s_ar*/s_r*             AXI4-Lite read address/data channels
//     addr_data_out          command word (ADDR_DATA register)
//     valid_addr_data_out    command-valid level
//     i2c_trigger            transaction trigger level
//     valid_data_ack(_valid) ack value / ack-valid level from I2C stage
//     rdata_in(_valid)       read byte / read-valid level from I2C stage
//     pending_wr/pending_rd  pending flags from I2C stage
//     irq                    STATUS.done & CTRL.irq_en
//
//   Register map (word address = addr[3:2])
//     0x0 ADDR_DATA RW[23:0]     0x4 CTRL  [0] START (W, reads 0) [1] irq_en
//     0x8 STATUS    RO + W1C on [1] done, [3] rvalid, [4] timeout
//         [0] busy [2] ack [5] pending_wr [6] pending_rd
//     0xC RDATA     RO[7:0]
module axi_i2c_regif #(
    parameter int unsigned HOLD_CYCLES    = 2000,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [3:0]  s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [23:0] addr_data_out,
    output logic        valid_addr_data_out,
    output logic        i2c_trigger,
    input  logic        valid_data_ack,
    input  logic        valid_data_ack_valid,
    input  logic [7:0]  rdata_in,
    input  logic        rdata_in_valid,
    input  logic        pending_wr,
    input  logic        pending_rd,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VALID,
        S_GAP,
        S_TRIG,
        S_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt;
    logic        cnt_reload;
    logic        timeout_hit;

    logic [23:0] addr_data;
    logic [7:0]  rdata_reg;
    logic        irq_en, busy, done, ack, rvalid_flag, timeout;
    logic        pend_wr, pend_rd;
    logic        ack_valid_q, rdata_valid_q;
    logic        ack_rise, rd_rise;

    logic        wr_hs, rd_hs, wr_err, start_req;
    logic [1:0]  wr_addr;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign unused_bits = ^{s_awaddr[1:0], s_araddr[1:0], s_wdata[31:24], s_wstrb[3]};

    // Ready is combinational on valid; an outstanding response blocks the
    // next handshake, so ready is a single-cycle pulse per transaction.
    assign s_awready = s_awvalid & s_wvalid & ~s_bvalid;
    assign s_wready  = s_awready;
    assign wr_hs     = s_awready;
    assign wr_addr   = s_awaddr[3:2];
    assign s_arready = s_arvalid & ~s_rvalid;
    assign rd_hs     = s_arready;
    assign s_rresp   = 2'b00;

    assign start_req = wr_hs & ~busy & (wr_addr == 2'd1) & s_wstrb[0] & s_wdata[0];
    assign wr_err    = wr_hs & busy &
                       ((wr_addr == 2'd0) | ((wr_addr == 2'd1) & s_wstrb[0] & s_wdata[0]));

    assign ack_rise  = valid_data_ack_valid & ~ack_valid_q;
    assign rd_rise   = rdata_in_valid & ~rdata_valid_q;

    assign addr_data_out = addr_data;
    assign irq           = done & irq_en;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        cnt_reload          = 1'b0;
        timeout_hit         = 1'b0;
        valid_addr_data_out = 1'b0;
        i2c_trigger         = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_reload = 1'b1;
                if (start_req) begin
                    state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                valid_addr_data_out = 1'b1;
                if (cnt == HOLD_CYCLES - 1) begin
                    state_nxt  = S_GAP;
                    cnt_reload = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == HOLD_CYCLES - 1) begin
                    state_nxt  = S_TRIG;
                    cnt_reload = 1'b1;
                end
            end
            S_TRIG: begin
                i2c_trigger = 1'b1;
                if (cnt == HOLD_CYCLES - 1) begin
                    state_nxt  = S_WAIT;
                    cnt_reload = 1'b1;
                end
            end
            S_WAIT: begin
                if (ack_rise | rd_rise) begin
                    state_nxt  = S_IDLE;
                    cnt_reload = 1'b1;
                end else if (cnt == TIMEOUT_CYCLES - 1) begin
                    state_nxt   = S_IDLE;
                    cnt_reload  = 1'b1;
                    timeout_hit = 1'b1;
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                cnt_reload = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (cnt_reload) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (s_araddr[3:2])
            2'd0: rd_mux = {8'h00, addr_data};
            2'd1: rd_mux = {30'h0, irq_en, 1'b0};
            2'd2: rd_mux = {25'h0, pend_rd, pend_wr, timeout, rvalid_flag, ack, done, busy};
            2'd3: rd_mux = {24'h0, rdata_reg};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_bvalid      <= 1'b0;
            s_bresp       <= 2'b00;
            s_rvalid      <= 1'b0;
            s_rdata       <= '0;
            addr_data     <= '0;
            rdata_reg     <= '0;
            irq_en        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ack           <= 1'b0;
            rvalid_flag   <= 1'b0;
            timeout       <= 1'b0;
            pend_wr       <= 1'b0;
            pend_rd       <= 1'b0;
            ack_valid_q   <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else begin
            ack_valid_q   <= valid_data_ack_valid;
            rdata_valid_q <= rdata_in_valid;
            pend_wr       <= pending_wr;
            pend_rd       <= pending_rd;

            if (wr_hs) begin
                s_bvalid <= 1'b1;
                s_bresp  <= wr_err ? 2'b10 : 2'b00;
            end else if (s_bready) begin
                s_bvalid <= 1'b0;
            end

            if (rd_hs) begin
                s_rvalid <= 1'b1;
                s_rdata  <= rd_mux;
            end else if (s_rready) begin
                s_rvalid <= 1'b0;
            end

            if (wr_hs && !wr_err) begin
                case (wr_addr)
                    2'd0: begin
                        for (int unsigned i = 0; i < 3; i++) begin
                            if (s_wstrb[i]) begin
                                addr_data[8*i +: 8] <= s_wdata[8*i +: 8];
                            end
                        end
                    end
                    2'd1: begin
                        if (s_wstrb[0]) begin
                            irq_en <= s_wdata[1];
                        end
                    end
                    2'd2: begin
                        if (s_wstrb[0]) begin
                            if (s_wdata[1]) done        <= 1'b0;
                            if (s_wdata[3]) rvalid_flag <= 1'b0;
                            if (s_wdata[4]) timeout     <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            // Flag updates come after the W1C handling so a set in the same
            // cycle overrides the clear.
            if (start_req) begin
                busy        <= 1'b1;
                done        <= 1'b0;
                ack         <= 1'b0;
                rvalid_flag <= 1'b0;
                timeout     <= 1'b0;
            end

            if (state == S_WAIT) begin
                if (ack_rise) begin
                    ack <= valid_data_ack;
                end
                if (rd_rise) begin
                    rdata_reg   <= rdata_in;
                    rvalid_flag <= 1'b1;
                end
                if (ack_rise | rd_rise | timeout_hit) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                if (timeout_hit) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_i2c_regif.sv
// tb_axi_i2c_regif
//   Self-checking bench for axi_i2c_regif with HOLD_CYCLES=8 and
//   TIMEOUT_CYCLES=100. AXI responses are checked against expectations
//   queued when each transaction is issued. Inputs are driven and outputs
//   sampled on the falling clock edge.
module tb_axi_i2c_regif;

    localparam int unsigned HOLD = 8;
    localparam int unsigned TMO  = 100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [3:0]  s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [23:0] addr_data_out;
    logic        valid_addr_data_out;
    logic        i2c_trigger;
    logic        valid_data_ack = 1'b0;
    logic        valid_data_ack_valid = 1'b0;
    logic [7:0]  rdata_in = '0;
    logic        rdata_in_valid = 1'b0;
    logic        pending_wr = 1'b0;
    logic        pending_rd = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    axi_i2c_regif #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .s_awaddr            (s_awaddr),
        .s_awvalid           (s_awvalid),
        .s_awready           (s_awready),
        .s_wdata             (s_wdata),
        .s_wstrb             (s_wstrb),
        .s_wvalid            (s_wvalid),
        .s_wready            (s_wready),
        .s_bresp             (s_bresp),
        .s_bvalid            (s_bvalid),
        .s_bready            (s_bready),
        .s_araddr            (s_araddr),
        .s_arvalid           (s_arvalid),
        .s_arready           (s_arready),
        .s_rdata             (s_rdata),
        .s_rresp             (s_rresp),
        .s_rvalid            (s_rvalid),
        .s_rready            (s_rready),
        .addr_data_out       (addr_data_out),
        .valid_addr_data_out (valid_addr_data_out),
        .i2c_trigger         (i2c_trigger),
        .valid_data_ack      (valid_data_ack),
        .valid_data_ack_valid(valid_data_ack_valid),
        .rdata_in            (rdata_in),
        .rdata_in_valid      (rdata_in_valid),
        .pending_wr          (pending_wr),
        .pending_rd          (pending_rd),
        .irq                 (irq)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] rd_exp_q[$];
    logic [1:0]  wr_exp_q[$];

    // Edge timestamps (in falling-edge counts) of the handoff levels and irq.
    int unsigned cyc = 0;
    int unsigned v_rise = 0, v_fall = 0, t_rise = 0, t_fall = 0, i_rise = 0;
    logic        v_d = 1'b0, t_d = 1'b0, i_d = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        v_d <= valid_addr_data_out;
        t_d <= i2c_trigger;
        i_d <= irq;
        if (valid_addr_data_out && !v_d) v_rise <= cyc;
        if (!valid_addr_data_out && v_d) v_fall <= cyc;
        if (i2c_trigger && !t_d)         t_rise <= cyc;
        if (!i2c_trigger && t_d)         t_fall <= cyc;
        if (irq && !i_d)                 i_rise <= cyc;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return i2c_trigger;
            1:       return irq;
            default: return valid_addr_data_out;
        endcase
    endfunction

    task automatic wait_level(input int sel, input logic lvl, input int unsigned max, input string tag);
        int unsigned n = 0;
        while (sig_sel(sel) !== lvl && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq(tag, 32'(sig_sel(sel)), 32'(lvl));
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er, input string tag);
        int unsigned n = 0;
        logic [1:0]  e;
        wr_exp_q.push_back(er);
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        while (!s_awready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq({tag, "_awready"}, 32'(s_awready), 32'd1);
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        #1;
        n = 0;
        while (!s_bvalid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq({tag, "_bvalid"}, 32'(s_bvalid), 32'd1);
        e = wr_exp_q.pop_front();
        check_eq({tag, "_bresp"}, 32'(s_bresp), 32'(e));
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        int unsigned n = 0;
        logic [31:0] e;
        rd_exp_q.push_back(exp);
        s_araddr = a; s_arvalid = 1'b1;
        #1;
        while (!s_arready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq({tag, "_arready"}, 32'(s_arready), 32'd1);
        @(negedge clk);
        s_arvalid = 1'b0;
        #1;
        n = 0;
        while (!s_rvalid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq({tag, "_rvalid"}, 32'(s_rvalid), 32'd1);
        e = rd_exp_q.pop_front();
        check_eq(tag, s_rdata, e);
        check_eq({tag, "_rresp"}, 32'(s_rresp), 32'd0);
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_addr_data_out", 32'(addr_data_out), 32'd0);
        check_eq("rst_valid", 32'(valid_addr_data_out), 32'd0);
        check_eq("rst_trig", 32'(i2c_trigger), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_bvalid", 32'(s_bvalid), 32'd0);
        check_eq("rst_rvalid", 32'(s_rvalid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        axi_read(4'h8, 32'h0, "rst_status");
        axi_read(4'h0, 32'h0, "rst_ad");

        // ADDR_DATA write/read, byte strobes, unmapped/RO, pending flags
        axi_write(4'h0, 32'h0000A55A, 4'hF, 2'b00, "wr_ad");
        axi_read(4'h0, 32'h0000A55A, "rd_ad");
        #1 check_eq("addr_data_out", 32'(addr_data_out), 32'h00A55A);
        axi_write(4'h0, 32'hFFFFFFFF, 4'b0010, 2'b00, "wr_ad_strb");
        axi_read(4'h0, 32'h0000FF5A, "rd_ad_strb");
        axi_write(4'h0, 32'h0000A55A, 4'hF, 2'b00, "wr_ad_restore");
        axi_write(4'hC, 32'h000000FF, 4'hF, 2'b00, "wr_rdata_ro");
        axi_read(4'hC, 32'h0, "rd_rdata_ro");
        pending_wr = 1'b1;
        @(negedge clk);
        axi_read(4'h8, 32'h20, "st_pend_wr");
        pending_wr = 1'b0; pending_rd = 1'b1;
        @(negedge clk);
        axi_read(4'h8, 32'h40, "st_pend_rd");
        pending_rd = 1'b0;
        @(negedge clk);

        // START: valid 8, gap 8, trigger 8, busy throughout
        axi_write(4'h4, 32'h1, 4'hF, 2'b00, "start1");
        axi_read(4'h8, 32'h1, "busy_a");
        axi_read(4'h4, 32'h0, "ctrl_start_rd0");
        wait_level(0, 1'b1, 40, "trig_rise1");
        axi_read(4'h8, 32'h1, "busy_trig");
        wait_level(0, 1'b0, 40, "trig_fall1");
        check_eq("valid_len", v_fall - v_rise, HOLD);
        check_eq("gap_len", t_rise - v_fall, HOLD);
        check_eq("trig_len", t_fall - t_rise, HOLD);

        // Read completion in WAIT
        rdata_in = 8'h3C; rdata_in_valid = 1'b1;
        @(negedge clk); #1;
        check_eq("irq_off_en0", 32'(irq), 32'd0);
        axi_read(4'h8, 32'h0A, "st_rd_done");
        axi_read(4'hC, 32'h3C, "rdata");
        rdata_in_valid = 1'b0;

        // Ack completion with irq enabled, then W1C done
        axi_write(4'h4, 32'h2, 4'hF, 2'b00, "irq_en");
        axi_read(4'h4, 32'h2, "ctrl_rd");
        #1 check_eq("irq_old_done", 32'(irq), 32'd1);
        axi_write(4'h4, 32'h3, 4'hF, 2'b00, "start2");
        #1 check_eq("irq_start_clr", 32'(irq), 32'd0);
        wait_level(0, 1'b0, 40, "trig_fall2_pre");
        wait_level(0, 1'b1, 40, "trig_rise2");
        wait_level(0, 1'b0, 40, "trig_fall2");
        valid_data_ack = 1'b1; valid_data_ack_valid = 1'b1;
        @(negedge clk); #1;
        check_eq("irq_ack", 32'(irq), 32'd1);
        axi_read(4'h8, 32'h06, "st_ack");
        #1 check_eq("irq_held", 32'(irq), 32'd1);
        axi_write(4'h8, 32'h2, 4'hF, 2'b00, "w1c_done");
        #1 check_eq("irq_w1c", 32'(irq), 32'd0);
        axi_read(4'h8, 32'h04, "st_after_w1c");
        valid_data_ack_valid = 1'b0; valid_data_ack = 1'b0;
        @(negedge clk);

        // Writes while busy are rejected; no completion -> timeout
        axi_write(4'h4, 32'h3, 4'hF, 2'b00, "start3");
        axi_write(4'h0, 32'h00123456, 4'hF, 2'b10, "ad_busy");
        axi_read(4'h0, 32'h0000A55A, "ad_frozen");
        #1 check_eq("addr_data_frozen", 32'(addr_data_out), 32'h00A55A);
        axi_write(4'h4, 32'h1, 4'hF, 2'b10, "start_busy");
        wait_level(0, 1'b1, 40, "trig_rise3");
        wait_level(0, 1'b0, 40, "trig_fall3");
        wait_level(1, 1'b1, 200, "irq_timeout");
        check_eq("timeout_len", i_rise - t_fall, TMO);
        axi_read(4'h8, 32'h12, "st_timeout");
        axi_write(4'h8, 32'h12, 4'hF, 2'b00, "w1c_to");
        axi_read(4'h8, 32'h0, "st_clr");

        // Reset in the middle of TRIG
        axi_write(4'h4, 32'h3, 4'hF, 2'b00, "start4");
        wait_level(0, 1'b1, 40, "trig_rise4");
        resetn = 1'b0;
        #1;
        check_eq("rst_mid_trig", 32'(i2c_trigger), 32'd0);
        check_eq("rst_mid_valid", 32'(valid_addr_data_out), 32'd0);
        check_eq("rst_mid_ad", 32'(addr_data_out), 32'd0);
        check_eq("rst_mid_irq", 32'(irq), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        axi_read(4'h8, 32'h0, "st_post_rst");
        axi_read(4'h4, 32'h0, "ctrl_post_rst");
        repeat (20) @(negedge clk);
        check_eq("trig_post_rst", 32'(i2c_trigger), 32'd0);
        check_eq("valid_post_rst", 32'(valid_addr_data_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
